// File: rtl/dp_ram_port_b_arbiter.sv
// Two-requester OBI-style arbiter for dual-port RAM port B.
// Define DP_RAM_ARB_RR_EN for round-robin priority; otherwise m0 has fixed priority.
module dp_ram_port_b_arbiter #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  m0_req_i,
  output logic                  m0_gnt_o,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  input  logic                  m0_we_i,
  input  logic [3:0]            m0_be_i,
  input  logic [31:0]           m0_wdata_i,
  output logic                  m0_rvalid_o,
  output logic [31:0]           m0_rdata_o,
  input  logic                  m1_req_i,
  output logic                  m1_gnt_o,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic                  m1_we_i,
  input  logic [3:0]            m1_be_i,
  input  logic [31:0]           m1_wdata_i,
  output logic                  m1_rvalid_o,
  output logic [31:0]           m1_rdata_o,
  output logic                  ram_en_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_we_o,
  output logic [3:0]            ram_be_o,
  output logic [31:0]           ram_wdata_o,
  input  logic [31:0]           ram_rdata_i
);

  logic gnt0;
  logic gnt1;
  logic pend_valid_q;
  logic pend_owner_q;
  logic pend_we_q;

`ifdef DP_RAM_ARB_RR_EN
  logic prio_q;
`endif

  // Grants are forced low while reset is asserted
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!rst_i) begin
`ifdef DP_RAM_ARB_RR_EN
      if (m0_req_i && (!m1_req_i || !prio_q)) begin
        gnt0 = 1'b1;
      end else if (m1_req_i) begin
        gnt1 = 1'b1;
      end
`else
      if (m0_req_i) begin
        gnt0 = 1'b1;
      end else if (m1_req_i) begin
        gnt1 = 1'b1;
      end
`endif
    end
  end

  assign m0_gnt_o = gnt0;
  assign m1_gnt_o = gnt1;
  assign ram_en_o = gnt0 | gnt1;

  always_comb begin
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'b0;
    ram_wdata_o = 32'b0;
    if (gnt0) begin
      ram_addr_o  = m0_addr_i;
      ram_we_o    = m0_we_i;
      ram_be_o    = m0_be_i;
      ram_wdata_o = m0_wdata_i;
    end else if (gnt1) begin
      ram_addr_o  = m1_addr_i;
      ram_we_o    = m1_we_i;
      ram_be_o    = m1_be_i;
      ram_wdata_o = m1_wdata_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_valid_q <= 1'b0;
      pend_owner_q <= 1'b0;
      pend_we_q    <= 1'b0;
    end else begin
      pend_valid_q <= ram_en_o;
      if (ram_en_o) begin
        pend_owner_q <= gnt1;
        pend_we_q    <= ram_we_o;
      end
    end
  end

`ifdef DP_RAM_ARB_RR_EN
  // After a grant, priority passes to the other requester
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else if (ram_en_o) begin
      prio_q <= gnt0;
    end
  end
`endif

  assign m0_rvalid_o = pend_valid_q & ~pend_owner_q;
  assign m1_rvalid_o = pend_valid_q & pend_owner_q;

  // Write responses carry zero data; the RAM keeps stale read data
  assign m0_rdata_o = (m0_rvalid_o && !pend_we_q) ? ram_rdata_i : 32'b0;
  assign m1_rdata_o = (m1_rvalid_o && !pend_we_q) ? ram_rdata_i : 32'b0;

endmodule

// File: tb/tb_dp_ram_port_b_arbiter.sv
// Self-checking bench for dp_ram_port_b_arbiter with a behavioural RAM.
// Follows DP_RAM_ARB_RR_EN the same way as the design.
module tb_dp_ram_port_b_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic        we0 = 1'b0, we1 = 1'b0;
  logic [3:0]  be0 = '0, be1 = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  logic        gnt0, gnt1, rv0, rv1;
  logic [31:0] rd0, rd1;
  logic        ram_en, ram_we;
  logic [7:0]  ram_addr;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = '0;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];

  always #5 clk = ~clk;

  dp_ram_port_b_arbiter #(.ADDR_WIDTH(8)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_req_i(req0), .m0_gnt_o(gnt0), .m0_addr_i(addr0),
    .m0_we_i(we0), .m0_be_i(be0), .m0_wdata_i(wd0),
    .m0_rvalid_o(rv0), .m0_rdata_o(rd0),
    .m1_req_i(req1), .m1_gnt_o(gnt1), .m1_addr_i(addr1),
    .m1_we_i(we1), .m1_be_i(be1), .m1_wdata_i(wd1),
    .m1_rvalid_o(rv1), .m1_rdata_o(rd1),
    .ram_en_o(ram_en), .ram_addr_o(ram_addr), .ram_we_o(ram_we),
    .ram_be_o(ram_be), .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  // Behavioural RAM: registered read, read data untouched by writes
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int b = 0; b < 4; b++)
          if (ram_be[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
      end else begin
        ram_rdata <= mem[ram_addr[7:2]];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: who should win, and which response is owed
  int          m_prio = 0;
  bit          p_valid = 0;
  int          p_owner = 0;
  bit          p_we = 0;
  logic [31:0] p_data = '0;

  always @(negedge clk) begin
    bit e0, e1, w;
    logic [7:0] a;
    logic [3:0] b;
    logic [31:0] d;
    e0 = 0; e1 = 0;
    if (!rst) begin
      if (req0 && req1) begin
        e0 = (m_prio == 0);
        e1 = (m_prio == 1);
      end else begin
        e0 = req0;
        e1 = req1;
      end
    end
    a = e0 ? addr0 : (e1 ? addr1 : 8'd0);
    w = e0 ? we0 : (e1 ? we1 : 1'b0);
    b = e0 ? be0 : (e1 ? be1 : 4'd0);
    d = e0 ? wd0 : (e1 ? wd1 : 32'd0);
    if (rst) p_valid = 0;
    chk("gnt0", {31'd0, gnt0}, {31'd0, e0});
    chk("gnt1", {31'd0, gnt1}, {31'd0, e1});
    chk("ram_en", {31'd0, ram_en}, {31'd0, e0 | e1});
    chk("ram_addr", {24'd0, ram_addr}, {24'd0, a});
    chk("ram_we", {31'd0, ram_we}, {31'd0, w});
    chk("ram_be", {28'd0, ram_be}, {28'd0, b});
    chk("ram_wdata", ram_wdata, d);
    chk("rvalid0", {31'd0, rv0}, {31'd0, p_valid && p_owner == 0});
    chk("rvalid1", {31'd0, rv1}, {31'd0, p_valid && p_owner == 1});
    chk("rdata0", rd0, (p_valid && p_owner == 0 && !p_we) ? p_data : 32'd0);
    chk("rdata1", rd1, (p_valid && p_owner == 1 && !p_we) ? p_data : 32'd0);
    if (rst) begin
      p_valid = 0;
      m_prio = 0;
    end else if (e0 || e1) begin
      p_valid = 1;
      p_owner = e1 ? 1 : 0;
      p_we = w;
      p_data = ref_mem[a[7:2]];
      if (w)
        for (int k = 0; k < 4; k++)
          if (b[k]) ref_mem[a[7:2]][8*k +: 8] = d[8*k +: 8];
`ifdef DP_RAM_ARB_RR_EN
      m_prio = e0 ? 1 : 0;
`endif
    end else begin
      p_valid = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rnd0();
    req0 = ($urandom_range(0, 3) != 0);
    addr0 = 8'($urandom_range(0, 255));
    we0 = 1'($urandom_range(0, 1));
    be0 = 4'($urandom);
    wd0 = $urandom;
  endtask

  task automatic rnd1();
    req1 = ($urandom_range(0, 3) != 0);
    addr1 = 8'($urandom_range(0, 255));
    we1 = 1'($urandom_range(0, 1));
    be1 = 4'($urandom);
    wd1 = $urandom;
  endtask

  initial begin
    int c0, c1;
    bit g0, g1;
    for (int i = 0; i < 64; i++) begin
      mem[i] = '0;
      ref_mem[i] = '0;
    end
    mem[4] = 32'hDEADBEEF;
    ref_mem[4] = 32'hDEADBEEF;

    // Reset with a pending m0 request
    step();
    req0 = 1'b1;
    addr0 = 8'h00;
    @(negedge clk);
    chk("rst_gnt0", {31'd0, gnt0}, 32'd0);
    chk("rst_en", {31'd0, ram_en}, 32'd0);
    chk("rst_rvalid0", {31'd0, rv0}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("release_gnt0", {31'd0, gnt0}, 32'd1);

    // Single read of 0x10
    step();
    addr0 = 8'h10;
    @(negedge clk);
    chk("rd_gnt0", {31'd0, gnt0}, 32'd1);
    chk("rd_addr", {24'd0, ram_addr}, 32'h10);
    step();
    req0 = 1'b0;
    @(negedge clk);
    chk("rd_rvalid0", {31'd0, rv0}, 32'd1);
    chk("rd_rdata0", rd0, 32'hDEADBEEF);
    chk("rd_rvalid1", {31'd0, rv1}, 32'd0);

    // m1 partial write then read-back
    step();
    req1 = 1'b1;
    addr1 = 8'h20;
    we1 = 1'b1;
    be1 = 4'b0011;
    wd1 = 32'h12345678;
    @(negedge clk);
    chk("wr_gnt1", {31'd0, gnt1}, 32'd1);
    step();
    we1 = 1'b0;
    @(negedge clk);
    chk("wr_rvalid1", {31'd0, rv1}, 32'd1);
    chk("wr_rdata1", rd1, 32'd0);
    step();
    req1 = 1'b0;
    @(negedge clk);
    chk("rb_rvalid1", {31'd0, rv1}, 32'd1);
    chk("rb_rdata1", rd1, 32'h00005678);

    // Contention for four cycles
    step();
    req0 = 1'b1;
    addr0 = 8'h10;
    req1 = 1'b1;
    addr1 = 8'h20;
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) chk("cont_first", {31'd0, gnt0}, 32'd1);
      c0 += int'(gnt0);
      c1 += int'(gnt1);
      if (i < 3) step();
    end
`ifdef DP_RAM_ARB_RR_EN
    chk("cont_m0", c0, 2);
    chk("cont_m1", c1, 2);
`else
    chk("cont_m0", c0, 4);
    chk("cont_m1", c1, 0);
`endif
    step();
    req0 = 1'b0;
    @(negedge clk);
    chk("drop_gnt1", {31'd0, gnt1}, 32'd1);
    step();
    req1 = 1'b0;

    // Reset while a read is in flight
    step();
    req0 = 1'b1;
    addr0 = 8'h10;
    @(negedge clk);
    chk("mid_gnt0", {31'd0, gnt0}, 32'd1);
    step();
    rst = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    chk("mid_rvalid0", {31'd0, rv0}, 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rvalid0", {31'd0, rv0}, 32'd0);
    step();
    @(negedge clk);
    chk("late_rvalid0", {31'd0, rv0}, 32'd0);

    // Random traffic; ungranted requests stay stable
    step();
    rnd0();
    rnd1();
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      g0 = gnt0;
      g1 = gnt1;
      step();
      if (!req0 || g0) rnd0();
      if (!req1 || g1) rnd1();
    end
    req0 = 1'b0;
    req1 = 1'b0;
    step();
    step();
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
